// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler sharing one sparse Kogge-Stone adder among R requesters,
// with carry-chained multi-word ops. Optional word counter: ADDER_SCHED_STATS_EN.

module sparse_kogge_stone_adder #(
  parameter int N = 8,
  parameter int K = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  localparam int NB = (N + K - 1) / K;
  localparam int LV = (NB > 1) ? $clog2(NB) : 1;

  // Block generate/propagate, Kogge-Stone prefix over block checkpoints, ripple inside blocks.
  function automatic logic [N:0] sks_add(input logic [N-1:0] x, input logic [N-1:0] y,
                                         input logic ci);
    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N-1:0] s;
    logic [NB-1:0] bg;
    logic [NB-1:0] bp;
    logic [NB:0] cb;
    logic c;
    int d;
    g = x & y;
    p = x ^ y;
    s = '0;
    c = 1'b0;
    for (int j = 0; j < NB; j++) begin
      bg[j] = 1'b0;
      bp[j] = 1'b1;
      for (int i = j * K; (i < j * K + K) && (i < N); i++) begin
        bg[j] = g[i] | (p[i] & bg[j]);
        bp[j] = bp[j] & p[i];
      end
    end
    for (int l = 0; l < LV; l++) begin
      d = 1 << l;
      for (int j = NB - 1; j >= d; j--) begin
        bg[j] = bg[j] | (bp[j] & bg[j-d]);
        bp[j] = bp[j] & bp[j-d];
      end
    end
    cb[0] = ci;
    for (int j = 0; j < NB; j++) begin
      cb[j+1] = bg[j] | (bp[j] & ci);
    end
    for (int j = 0; j < NB; j++) begin
      c = cb[j];
      for (int i = j * K; (i < j * K + K) && (i < N); i++) begin
        s[i] = p[i] ^ c;
        c    = g[i] | (p[i] & c);
      end
    end
    return {cb[NB], s};
  endfunction

  assign {cout, sum} = sks_add(a, b, cin);
endmodule

module adder_rr_scheduler #(
  parameter int N = 8,
  parameter int K = 4,
  parameter int R = 4,
  parameter int IW = $clog2(R)
) (
  input  logic           CLOCK_50,
  input  logic           rst_n,
  input  logic [R-1:0]   req_valid,
  output logic [R-1:0]   req_ready,
  input  logic [R*N-1:0] req_a,
  input  logic [R*N-1:0] req_b,
  input  logic [R-1:0]   req_cin,
  input  logic [R-1:0]   req_last,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [N-1:0]   rsp_sum,
  output logic           rsp_cout,
  output logic [IW-1:0]  rsp_id,
  output logic [31:0]    stat_words
);
  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t        state_r, state_n;
  logic [IW-1:0] ptr_r, ptr_n;
  logic [IW-1:0] owner_r, owner_n;
  logic          carry_r, carry_n;

  logic          rsp_valid_r;
  logic [N-1:0]  rsp_sum_r;
  logic          rsp_cout_r;
  logic [IW-1:0] rsp_id_r;

  logic [IW-1:0] rr_idx_s;
  logic          rr_found_s;
  logic [IW-1:0] gnt_idx_s;
  logic          gnt_ok_s;
  logic          free_s;
  logic          accept_s;
  logic          last_s;
  logic [N-1:0]  add_a_s;
  logic [N-1:0]  add_b_s;
  logic          add_cin_s;
  logic [N-1:0]  add_sum_s;
  logic          add_cout_s;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == IW'(R - 1)) ? '0 : i + IW'(1);
  endfunction

  // First valid requester scanning from ptr upward, wrapping mod R.
  always_comb begin
    int idx;
    rr_found_s = 1'b0;
    rr_idx_s   = '0;
    idx        = 0;
    for (int i = 0; i < R; i++) begin
      idx = (int'(ptr_r) + i) % R;
      if (!rr_found_s && req_valid[idx]) begin
        rr_found_s = 1'b1;
        rr_idx_s   = IW'(idx);
      end else begin
        rr_found_s = rr_found_s;
      end
    end
  end

  // Grant source and adder carry-in depend on whether a chain holds the adder.
  always_comb begin
    gnt_idx_s = rr_idx_s;
    gnt_ok_s  = rr_found_s;
    add_cin_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        gnt_idx_s = rr_idx_s;
        gnt_ok_s  = rr_found_s;
        add_cin_s = req_cin[rr_idx_s];
      end
      ST_LOCKED: begin
        gnt_idx_s = owner_r;
        gnt_ok_s  = req_valid[owner_r];
        add_cin_s = carry_r;
      end
      default: begin
        gnt_ok_s  = 1'b0;
        add_cin_s = 1'b0;
      end
    endcase
  end

  assign free_s   = !rsp_valid_r || rsp_ready;
  assign accept_s = rst_n && free_s && gnt_ok_s;
  assign last_s   = req_last[gnt_idx_s];
  assign add_a_s  = req_a[gnt_idx_s*N +: N];
  assign add_b_s  = req_b[gnt_idx_s*N +: N];

  // One-hot ready for the current grant only.
  always_comb begin
    req_ready = '0;
    for (int r = 0; r < R; r++) begin
      req_ready[r] = accept_s && (gnt_idx_s == IW'(r));
    end
  end

  sparse_kogge_stone_adder #(.N(N), .K(K)) u_adder (
    .a    (add_a_s),
    .b    (add_b_s),
    .cin  (add_cin_s),
    .sum  (add_sum_s),
    .cout (add_cout_s)
  );

  // Lock / pointer / carry next-state.
  always_comb begin
    state_n = state_r;
    ptr_n   = ptr_r;
    owner_n = owner_r;
    carry_n = carry_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && last_s) begin
          ptr_n = next_idx(gnt_idx_s);
        end else if (accept_s) begin
          state_n = ST_LOCKED;
          owner_n = gnt_idx_s;
          carry_n = add_cout_s;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (accept_s && last_s) begin
          state_n = ST_IDLE;
          ptr_n   = next_idx(owner_r);
        end else if (accept_s) begin
          carry_n = add_cout_s;
        end else begin
          state_n = ST_LOCKED;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      ptr_r   <= '0;
      owner_r <= '0;
      carry_r <= 1'b0;
    end else begin
      state_r <= state_n;
      ptr_r   <= ptr_n;
      owner_r <= owner_n;
      carry_r <= carry_n;
    end
  end

  // Response slot: load on accept (even while draining), otherwise clear on drain.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r <= 1'b0;
      rsp_sum_r   <= '0;
      rsp_cout_r  <= 1'b0;
      rsp_id_r    <= '0;
    end else if (accept_s) begin
      rsp_valid_r <= 1'b1;
      rsp_sum_r   <= add_sum_s;
      rsp_cout_r  <= add_cout_s;
      rsp_id_r    <= gnt_idx_s;
    end else if (rsp_ready) begin
      rsp_valid_r <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_sum   = rsp_sum_r;
  assign rsp_cout  = rsp_cout_r;
  assign rsp_id    = rsp_id_r;

`ifdef ADDER_SCHED_STATS_EN
  logic [31:0] stat_words_r;

  // Accepted-word counter, wraps naturally.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      stat_words_r <= 32'd0;
    end else if (accept_s) begin
      stat_words_r <= stat_words_r + 32'd1;
    end
  end

  assign stat_words = stat_words_r;
`else
  assign stat_words = 32'd0;
`endif

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Scoreboard bench for adder_rr_scheduler: stimulus pushes expected {id,sum,cout},
// a negedge monitor pops and compares on every response handshake.
module tb_adder_rr_scheduler;
  localparam int N  = 8;
  localparam int K  = 4;
  localparam int R  = 4;
  localparam int IW = 2;

  logic           CLOCK_50 = 1'b0;
  logic           rst_n;
  logic [R-1:0]   req_valid;
  logic [R-1:0]   req_ready;
  logic [R*N-1:0] req_a;
  logic [R*N-1:0] req_b;
  logic [R-1:0]   req_cin;
  logic [R-1:0]   req_last;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [N-1:0]   rsp_sum;
  logic           rsp_cout;
  logic [IW-1:0]  rsp_id;
  logic [31:0]    stat_words;

  int checks = 0;
  int passes = 0;
  logic [IW+N:0] exp_q[$];
  logic [IW+N:0] mon_e;
  logic [31:0]   exp_stat;

  always #5 CLOCK_50 = ~CLOCK_50;

  adder_rr_scheduler #(.N(N), .K(K), .R(R)) dut (
    .CLOCK_50   (CLOCK_50),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_cin    (req_cin),
    .req_last   (req_last),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .rsp_id     (rsp_id),
    .stat_words (stat_words)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic set_req(input int r, input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input logic l);
    req_a[r*N +: N] = a;
    req_b[r*N +: N] = b;
    req_cin[r]      = ci;
    req_last[r]     = l;
    req_valid[r]    = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_sum"},   32'(rsp_sum),   32'd0);
    chk({tag, "_rsp_cout"},  32'(rsp_cout),  32'd0);
    chk({tag, "_rsp_id"},    32'(rsp_id),    32'd0);
    chk({tag, "_stat"},      stat_words,     32'd0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
  endtask

  // Monitor: every response handshake consumes one expected entry.
  always @(negedge CLOCK_50) begin
    if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL rsp_unexpected: got id=%0d sum=0x%0h cout=%0d, expected no response",
                 rsp_id, rsp_sum, rsp_cout);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_word", 32'({rsp_id, rsp_sum, rsp_cout}), 32'(mon_e));
      end
    end
  end

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b0;
    req_valid = '0; req_a = '0; req_b = '0; req_cin = '0; req_last = '0;
    set_req(0, 8'h11, 8'h22, 1'b0, 1'b1);
    tick(); tick();
    chk_reset_outputs("reset");
    req_valid = '0;
    rst_n = 1'b1; rsp_ready = 1'b1;
    tick();

    // single op
    set_req(0, 8'h5A, 8'h3C, 1'b0, 1'b1); #1;
    chk("single_ready", 32'(req_ready), 32'h1);
    exp_q.push_back({2'd0, 8'h96, 1'b0});
    tick(); req_valid = '0;

    // carry edges
    set_req(1, 8'hFF, 8'h01, 1'b0, 1'b1); #1;
    chk("carry1_ready", 32'(req_ready), 32'h2);
    exp_q.push_back({2'd1, 8'h00, 1'b1});
    tick(); req_valid = '0;
    set_req(3, 8'hFF, 8'h00, 1'b1, 1'b1); #1;
    chk("carry2_ready", 32'(req_ready), 32'h8);
    exp_q.push_back({2'd3, 8'h00, 1'b1});
    tick(); req_valid = '0;

    // round robin, all requesters valid
    for (int r = 0; r < R; r++) set_req(r, 8'(r * 17), 8'h01, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_grant", 32'(req_ready), 32'(1 << (i % 4)));
      exp_q.push_back({2'(i % 4), 8'((i % 4) * 17 + 1), 1'b0});
      tick();
    end
    req_valid = '0;

    // chain lock on req2 with req1 waiting
    set_req(1, 8'h01, 8'h01, 1'b0, 1'b1);
    set_req(2, 8'hFF, 8'h01, 1'b0, 1'b0); #1;
    chk("chain_w0_ready", 32'(req_ready), 32'h4);
    exp_q.push_back({2'd2, 8'h00, 1'b1});
    tick();
    req_valid[2] = 1'b0; #1;
    chk("chain_hold_ready", 32'(req_ready), 32'h0);
    tick();
    set_req(2, 8'h12, 8'h34, 1'b1, 1'b1); #1;
    chk("chain_w1_ready", 32'(req_ready), 32'h4);
    exp_q.push_back({2'd2, 8'h47, 1'b0});
    tick();
    req_valid[2] = 1'b0; #1;
    chk("chain_after_ready", 32'(req_ready), 32'h2);
    exp_q.push_back({2'd1, 8'h02, 1'b0});
    tick(); req_valid = '0;
    tick();

    // backpressure
    rsp_ready = 1'b0;
    set_req(0, 8'h40, 8'h41, 1'b0, 1'b1); #1;
    chk("bp_first_ready", 32'(req_ready), 32'h1);
    exp_q.push_back({2'd0, 8'h81, 1'b0});
    tick(); req_valid = '0;
    set_req(3, 8'h0F, 8'h01, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_ready", 32'(req_ready), 32'h0);
      chk("bp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_hold", 32'({rsp_id, rsp_sum, rsp_cout}), 32'({2'd0, 8'h81, 1'b0}));
      tick();
    end
    rsp_ready = 1'b1; #1;
    chk("bp_release_ready", 32'(req_ready), 32'h8);
    exp_q.push_back({2'd3, 8'h11, 1'b0});
    tick(); req_valid = '0;
    tick();

    // reset mid-chain: pending word0 response is discarded
    rsp_ready = 1'b0;
    set_req(2, 8'hFF, 8'h01, 1'b0, 1'b0); #1;
    chk("rst_chain_ready", 32'(req_ready), 32'h4);
    tick();
    rst_n = 1'b0; #1;
    chk_reset_outputs("midreset");
    tick();
    rst_n = 1'b1; rsp_ready = 1'b1;
    set_req(2, 8'h10, 8'h20, 1'b0, 1'b1);
    set_req(0, 8'h01, 8'h02, 1'b1, 1'b1); #1;
    chk("post_rst_ready0", 32'(req_ready), 32'h1);
    exp_q.push_back({2'd0, 8'h04, 1'b0});
    tick();
    req_valid[0] = 1'b0; #1;
    chk("post_rst_ready2", 32'(req_ready), 32'h4);
    exp_q.push_back({2'd2, 8'h30, 1'b0});
    tick(); req_valid = '0;
`ifdef ADDER_SCHED_STATS_EN
    exp_stat = 32'd2;
`else
    exp_stat = 32'd0;
`endif
    chk("stat_words", stat_words, exp_stat);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
